sb_arbiter: RTL and testbench

Single-port system-bus arbiter sharing one memory port between instruction fetch and executrol load/store. It sits between the core's fetch/executrol outputs and the system bus (sb). It serialises accesses with one transaction outstanding and gives data priority over fetch, with an optional starvation guard. It drives the pipeline hold while a data access is unfinished.

---
 rtl/sb_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sb_arbiter.sv
// sb_arbiter: shares one system-bus memory port between instruction fetch
// and data load/store. One transaction outstanding; data wins over fetch.
// Optional starvation guard compiled in with `define SB_STARVE_GUARD_EN:
// after MAX_DATA_RUN contested data grants, fetch is granted once.
module sb_arbiter #(
   parameter int MAX_DATA_RUN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_re,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byte_sel,
   input  logic        d_un_sign,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        hold_o,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_byte_sel,
   output logic        m_un_sign,
   input  logic        m_ready,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  bsel_q, bsel_d;
   logic        usign_q, usign_d;

   logic        d_pend_s;
   logic        fetch_first_s;
   logic        if_gnt_s, d_gnt_s, if_rv_s, d_rv_s, m_req_s;

   assign d_pend_s = d_re | d_we;

`ifdef SB_STARVE_GUARD_EN
   localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
   logic [RUN_W-1:0] run_q, run_d;

   // Fetch wins when data is idle, or when data has had its full run while fetch waited.
   assign fetch_first_s = if_req & (~d_pend_s | (run_q == RUN_W'(MAX_DATA_RUN)));

   // Count contested data grants; any fetch grant restarts the run.
   always_comb begin
      run_d = run_q;
      if (state_q == S_IDLE && fetch_first_s) begin
         run_d = '0;
      end else if (state_q == S_IDLE && d_pend_s && if_req && run_q != RUN_W'(MAX_DATA_RUN)) begin
         run_d = run_q + RUN_W'(1);
      end else begin
         run_d = run_q;
      end
   end

   // Run counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end
`else
   // Strict data priority; the run limit has no effect in this build.
   localparam int unused_max_run_c = MAX_DATA_RUN;
   assign fetch_first_s = if_req & ~d_pend_s;
`endif

   // Arbitration, request latching and transaction sequencing.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      bsel_d   = bsel_q;
      usign_d  = usign_q;
      m_req_s  = 1'b0;
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
      if_rv_s  = 1'b0;
      d_rv_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fetch_first_s) begin
               owner_d = OWN_FETCH;
               we_d    = 1'b0;
               addr_d  = if_addr;
               wdata_d = 32'h0000_0000;
               bsel_d  = 4'b1111;
               usign_d = 1'b0;
               state_d = S_REQ;
            end else if (d_pend_s) begin
               // A simultaneous read+write request is served as a write.
               owner_d = OWN_DATA;
               we_d    = d_we;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               bsel_d  = d_byte_sel;
               usign_d = d_un_sign;
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            m_req_s = 1'b1;
            if (m_ready) begin
               if (owner_q == OWN_DATA) begin
                  d_gnt_s = 1'b1;
               end else begin
                  if_gnt_s = 1'b1;
               end
               state_d = we_q ? S_IDLE : S_RESP;
            end else begin
               state_d = S_REQ;
            end
         end
         S_RESP: begin
            if (m_rvalid) begin
               if (owner_q == OWN_DATA) begin
                  d_rv_s = 1'b1;
               end else begin
                  if_rv_s = 1'b1;
               end
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched request fields; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         owner_q <= OWN_FETCH;
         we_q    <= 1'b0;
         addr_q  <= 32'h0000_0000;
         wdata_q <= 32'h0000_0000;
         bsel_q  <= 4'b0000;
         usign_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         bsel_q  <= bsel_d;
         usign_q <= usign_d;
      end
   end

   assign m_req      = m_req_s;
   assign m_we       = we_q;
   assign m_addr     = addr_q;
   assign m_wdata    = wdata_q;
   assign m_byte_sel = bsel_q;
   assign m_un_sign  = usign_q;
   assign if_gnt     = if_gnt_s;
   assign d_gnt      = d_gnt_s;
   assign if_rvalid  = if_rv_s;
   assign d_rvalid   = d_rv_s;
   assign if_rdata   = if_rv_s ? m_rdata : 32'h0000_0000;
   assign d_rdata    = d_rv_s ? m_rdata : 32'h0000_0000;
   // Stall while data is pending unless a write is accepted or a load returns now.
   assign hold_o     = d_pend_s & ~(d_gnt_s & we_q) & ~d_rv_s;

endmodule

// File: tb/tb_sb_arbiter.sv
// Directed bench for sb_arbiter: vector table for single transactions and
// contention, plus hand sequences for grant ordering and reset mid-response.
module tb_sb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_re, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_byte_sel;
   logic        d_un_sign;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        hold_o;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_byte_sel;
   logic        m_un_sign;
   logic        m_ready, m_rvalid;
   logic [31:0] m_rdata;

   int total = 0;
   int bad   = 0;

   sb_arbiter #(.MAX_DATA_RUN(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byte_sel(d_byte_sel), .d_un_sign(d_un_sign),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .hold_o(hold_o),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_byte_sel(m_byte_sel), .m_un_sign(m_un_sign),
      .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ifr;
      logic [31:0] ifa;
      logic        dre, dwe;
      logic [31:0] da, dwd;
      logic [3:0]  bs;
      logic        us;
      logic        rdy, rv;
      logic [31:0] rd;
      logic [127:0] exp;
      logic        chkw;
      logic [36:0] expw;
   } vec_t;

   vec_t v [20];

   function automatic logic [127:0] pk(logic mreq, logic mwe, logic [31:0] maddr,
                                       logic ig, logic irv, logic [31:0] ird,
                                       logic dg, logic drv, logic [31:0] drd, logic hold);
      return {25'd0, mreq, mwe, maddr, ig, irv, ird, dg, drv, drd, hold};
   endfunction

   function automatic vec_t mk(logic ifr, logic [31:0] ifa, logic dre, logic dwe,
                               logic [31:0] da, logic [31:0] dwd, logic [3:0] bs, logic us,
                               logic rdy, logic rv, logic [31:0] rd,
                               logic [127:0] exp, logic chkw, logic [36:0] expw);
      vec_t r;
      r.ifr = ifr; r.ifa = ifa; r.dre = dre; r.dwe = dwe; r.da = da; r.dwd = dwd;
      r.bs = bs; r.us = us; r.rdy = rdy; r.rv = rv; r.rd = rd;
      r.exp = exp; r.chkw = chkw; r.expw = expw;
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = 32'h0; d_re = 1'b0; d_we = 1'b0;
      d_addr = 32'h0; d_wdata = 32'h0; d_byte_sel = 4'h0; d_un_sign = 1'b0;
      m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = 32'h0;
   endtask

   logic [127:0] act_s;
   logic [5:0]   got_order;
   logic [5:0]   exp_order;
   int           n_gnt;
   int           cyc;

   initial begin
      // fetch read, zero-wait memory
      v[0]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      v[1]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      v[2]  = mk(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h13,
                 pk(1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      v[3]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      // store with two wait cycles
      v[4]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                 pk(1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1), 1'b0, 37'h0);
      v[5]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                 pk(1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1), 1'b1,
                 {32'hDEADBEEF, 4'hF, 1'b0});
      v[6]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                 pk(1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1), 1'b0, 37'h0);
      v[7]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      v[8]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b0, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      // read+write together behaves as a write; stray m_rvalid in IDLE ignored
      v[9]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'h55, 4'h3, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b0, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1), 1'b0, 37'h0);
      v[10] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'h55, 4'h3, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0), 1'b1,
                 {32'h55, 4'h3, 1'b0});
      v[11] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hAAAA0000,
                 pk(1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      v[12] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      // contention: data load first, then fetch
      v[13] = mk(1'b1, 32'h104, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0, 32'h0,
                 pk(1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1), 1'b0, 37'h0);
      v[14] = mk(1'b1, 32'h104, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0, 32'h0,
                 pk(1'b1, 1'b0, 32'h4000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1), 1'b1,
                 {32'h0, 4'h1, 1'b1});
      v[15] = mk(1'b1, 32'h104, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h1, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D,
                 pk(1'b0, 1'b0, 32'h4000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0), 1'b0, 37'h0);
      v[16] = mk(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b0, 1'b0, 32'h4000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      v[17] = mk(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      v[18] = mk(1'b0, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h77,
                 pk(1'b0, 1'b0, 32'h104, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);
      v[19] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 pk(1'b0, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0, 37'h0);

      // reset state
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      act_s = pk(m_req, m_we, m_addr, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, hold_o);
      chk("reset_outputs", act_s, 128'h0);
      chk("reset_latches", {91'h0, m_wdata, m_byte_sel, m_un_sign}, 128'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // vector table
      for (int i = 0; i < 20; i++) begin
         if_req = v[i].ifr; if_addr = v[i].ifa; d_re = v[i].dre; d_we = v[i].dwe;
         d_addr = v[i].da; d_wdata = v[i].dwd; d_byte_sel = v[i].bs; d_un_sign = v[i].us;
         m_ready = v[i].rdy; m_rvalid = v[i].rv; m_rdata = v[i].rd;
         @(negedge clk);
         act_s = pk(m_req, m_we, m_addr, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, hold_o);
         chk($sformatf("vec%0d", i), act_s, v[i].exp);
         if (v[i].chkw) begin
            chk($sformatf("vec%0d_wfields", i), {91'h0, m_wdata, m_byte_sel, m_un_sign}, {91'h0, v[i].expw});
         end
         @(posedge clk); #1;
      end

      // grant order with both requesters held continuously
      if_req = 1'b1; if_addr = 32'h200; d_re = 1'b1; d_addr = 32'h5000;
      m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1234;
      got_order = 6'b0; n_gnt = 0; cyc = 0;
      while (n_gnt < 6 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (if_gnt || d_gnt) begin
            got_order[n_gnt] = if_gnt;
            n_gnt++;
         end
      end
`ifdef SB_STARVE_GUARD_EN
      exp_order = 6'b100100;
`else
      exp_order = 6'b000000;
`endif
      chk("grant_count", 128'(n_gnt), 128'(6));
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("grant%0d_is_fetch", k), {127'h0, got_order[k]}, {127'h0, exp_order[k]});
      end
      @(posedge clk); #1;
      if_req = 1'b0; d_re = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      idle_inputs();
      @(posedge clk); #1;

      // reset while waiting for a load response
      d_re = 1'b1; d_addr = 32'h6000; m_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_seq_dgnt", {127'h0, d_gnt}, {127'h0, 1'b1});
      @(posedge clk); #1;
      d_re = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      act_s = pk(m_req, m_we, m_addr, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, hold_o);
      chk("rst_mid_resp_outputs", act_s, 128'h0);
      #2 rst = 1'b1;
      for (int j = 0; j < 2; j++) begin
         @(posedge clk); #1;
         m_rvalid = 1'b1; m_rdata = 32'h99;
         @(negedge clk);
         act_s = pk(m_req, m_we, m_addr, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, hold_o);
         chk($sformatf("late_rvalid_ignored%0d", j), act_s, 128'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
